// File: rtl/spi_serializer_pkg.sv
// Shared definitions for the spi_serializer block: FSM state encoding,
// the registered-output control struct and the SCLK divider helpers.
// Optional readback path is enabled with macro SPI_SERIALIZER_READBACK_EN.
package spi_serializer_pkg;

   // Transfer phases; 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_t;

   // Every registered control output lives in one struct so the whole
   // FSM state (phase plus pin levels) can be observed as a single signal.
   typedef struct packed {
      spi_state_t state;
      logic       ready;
      logic       done;
      logic       sclk;
      logic       mosi;
      logic       cs_n;
   } spi_ctrl_t;

   localparam spi_ctrl_t CTRL_RESET = '{
      state : ST_IDLE,
      ready : 1'b1,
      done  : 1'b0,
      sclk  : 1'b0,
      mosi  : 1'b0,
      cs_n  : 1'b1
   };

   // Half-period reload value: ticks come every DIV+1 clocks.
   // A non-positive SCLK frequency yields -1 so elaboration rejects it.
   function automatic int calc_div(input int ifreq, input int sclk_freq);
      if (sclk_freq <= 0) return -1;
      return ifreq / (sclk_freq * 2) - 1;
   endfunction

   // Counter width able to hold DIV, never narrower than one bit.
   function automatic int cnt_width(input int div);
      if (div < 1) return 1;
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/spi_serializer_tick_gen.sv
// Reloadable half-period counter producing the SCLK tick strobe.
// The tick is high whenever the counter sits at zero; i_load restarts the
// count at DIV so the first tick after a load lands DIV+1 clocks later.
module spi_tick_gen
   import spi_serializer_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_load,
   output logic o_tick
);

   localparam int CW = cnt_width(DIV);

   logic [CW-1:0] cnt_q;

   assign o_tick = (cnt_q == '0);

   // Load has priority; otherwise count down and wrap to DIV on a tick.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= CW'(DIV);
      end else if (o_tick) begin
         cnt_q <= CW'(DIV);
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/spi_serializer.sv
// SPI mode-0 master transmitter. SCLK is generated from an i_clk tick
// strobe, so every output is a plain register in the i_clk domain.
// Words are shifted MSB first inside a chip-select frame.
// Optional macro SPI_SERIALIZER_READBACK_EN builds a receive shift register
// fed from i_miso; without it o_rdata is tied to zero and i_miso is unused.
//
// Handshake: a word is taken on any clock edge where i_valid && o_ready.
// o_ready is high only while idle (including the o_done cycle, so a new
// word can be taken back-to-back); i_valid while o_ready is low is ignored
// and nothing is queued.
module spi_serializer
   import spi_serializer_pkg::*;
#(
   parameter int IFREQ     = 96000000,
   parameter int SCLK_FREQ = 16000000,
   parameter int WIDTH     = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_done,
   output logic             o_sclk,
   output logic             o_mosi,
   output logic             o_cs_n,
   input  logic             i_miso,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int DIV      = calc_div(IFREQ, SCLK_FREQ);
   localparam int TICK_DIV = (DIV < 0) ? 0 : DIV;
   localparam int BCW      = $clog2(WIDTH + 1);

   generate
      if (DIV < 0) begin : g_bad_div
         $error("spi_serializer: SCLK_FREQ too high for IFREQ (DIV < 0)");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("spi_serializer: WIDTH must be at least 1");
      end
   endgenerate

   spi_ctrl_t        ctrl_q, ctrl_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic             tick;
   logic             tick_load;

`ifdef SPI_SERIALIZER_READBACK_EN
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
`endif

   spi_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (tick_load),
      .o_tick    (tick)
   );

   // Next-state and next-output logic; all pins are registered below.
   always_comb begin
      ctrl_d      = ctrl_q;
      ctrl_d.done = 1'b0;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      tick_load   = 1'b0;
`ifdef SPI_SERIALIZER_READBACK_EN
      rx_d        = rx_q;
      rdata_d     = rdata_q;
`endif
      case (ctrl_q.state)
         ST_IDLE: begin
            if (i_valid && ctrl_q.ready) begin
               tick_load    = 1'b1;
               ctrl_d.state = ST_SETUP;
               ctrl_d.ready = 1'b0;
               ctrl_d.cs_n  = 1'b0;
               ctrl_d.mosi  = i_data[WIDTH-1];
               shreg_d      = i_data;
               bitcnt_d     = '0;
`ifdef SPI_SERIALIZER_READBACK_EN
               rx_d         = '0;
`endif
            end
         end
         // One half period with CS low and the MSB already on MOSI.
         ST_SETUP: begin
            if (tick) begin
               ctrl_d.state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!ctrl_q.sclk) begin
                  // Rising edge: the slave samples MOSI here.
                  ctrl_d.sclk = 1'b1;
                  bitcnt_d    = bitcnt_q + 1'b1;
`ifdef SPI_SERIALIZER_READBACK_EN
                  rx_d        = (rx_q << 1) | WIDTH'(i_miso);
`endif
               end else begin
                  // Falling edge: present the next bit, except after the last.
                  ctrl_d.sclk = 1'b0;
                  if (bitcnt_q == BCW'(WIDTH)) begin
                     ctrl_d.state = ST_HOLD;
                  end else begin
                     shreg_d     = shreg_q << 1;
                     ctrl_d.mosi = shreg_d[WIDTH-1];
                  end
               end
            end
         end
         // CS hold half period after the final falling edge.
         ST_HOLD: begin
            if (tick) begin
               ctrl_d.state = ST_IDLE;
               ctrl_d.cs_n  = 1'b1;
               ctrl_d.ready = 1'b1;
               ctrl_d.done  = 1'b1;
`ifdef SPI_SERIALIZER_READBACK_EN
               rdata_d      = rx_q;
`endif
            end
         end
         default: begin
            ctrl_d = CTRL_RESET;
         end
      endcase
   end

   // FSM, pin and shift register state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ctrl_q   <= CTRL_RESET;
         shreg_q  <= '0;
         bitcnt_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
      end
   end

`ifdef SPI_SERIALIZER_READBACK_EN
   // Receive shift register and the word latched at end of transfer.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;
`else
   logic unused_miso;
   assign unused_miso = i_miso;
   assign o_rdata     = '0;
`endif

   assign o_ready = ctrl_q.ready;
   assign o_done  = ctrl_q.done;
   assign o_sclk  = ctrl_q.sclk;
   assign o_mosi  = ctrl_q.mosi;
   assign o_cs_n  = ctrl_q.cs_n;

endmodule

// File: tb/tb_spi_serializer.sv
// Bench for spi_serializer: instance A at DIV=2, instance B at DIV=0.
// Drivers push expected words into queues; negedge monitors pop and compare
// whenever a DUT raises o_done.
`timescale 1ns/1ps
module tb_spi_serializer;

   localparam int W      = 8;
   localparam int LAT_A  = 55;
   localparam int CSLO_A = 54;
   localparam int LAT_B  = 19;
   localparam int CSLO_B = 18;
`ifdef SPI_SERIALIZER_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] data_a = '0, data_b = '0;
   logic         valid_a = 1'b0, valid_b = 1'b0;
   logic         rdy_a, done_a, sclk_a, mosi_a, cs_n_a;
   logic         rdy_b, done_b, sclk_b, mosi_b, cs_n_b;
   logic [W-1:0] rdata_a, rdata_b;

   spi_serializer #(.IFREQ(96000000), .SCLK_FREQ(16000000), .WIDTH(W)) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(data_a), .i_valid(valid_a),
      .o_ready(rdy_a), .o_done(done_a), .o_sclk(sclk_a), .o_mosi(mosi_a),
      .o_cs_n(cs_n_a), .i_miso(mosi_a), .o_rdata(rdata_a));

   spi_serializer #(.IFREQ(96000000), .SCLK_FREQ(48000000), .WIDTH(W)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(data_b), .i_valid(valid_b),
      .o_ready(rdy_b), .o_done(done_b), .o_sclk(sclk_b), .o_mosi(mosi_b),
      .o_cs_n(cs_n_b), .i_miso(mosi_b), .o_rdata(rdata_b));

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_rd_q[$];
   logic [W-1:0] exp_b_q[$];
   logic [W-1:0] exp_rd_b_q[$];
   bit b2b_arm    = 1'b0;
   bit cs_gap_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor A: collects MOSI at SCLK rises, frame timing and handshake.
   logic [W-1:0] bits_a = '0;
   int nbits_a = 0, acc_a = 0, cslo_a = 0, rdyhi_a = 0, hirun_a = 0, last_done_a = -100;
   bit inx_a = 1'b0, sclk_prev_a = 1'b0, cs_prev_a = 1'b1;

   always @(negedge clk) begin
      logic [W-1:0] w, r;
      if (!rst_n) begin
         inx_a   = 1'b0;
         nbits_a = 0;
         hirun_a = 0;
      end else begin
         if (sclk_a && !sclk_prev_a) begin
            bits_a = {bits_a[W-2:0], mosi_a};
            nbits_a++;
         end
         if (done_a) begin
            check("a_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               r = exp_rd_q.pop_front();
               check("a_word", 32'(bits_a), 32'(w));
               check("a_rises", nbits_a, W);
               check("a_latency", cyc - acc_a, LAT_A);
               check("a_cs_low", cslo_a, CSLO_A);
               check("a_ready_busy", rdyhi_a, 0);
               check("a_rdata", 32'(rdata_a), 32'(r));
            end
            inx_a       = 1'b0;
            last_done_a = cyc;
         end
         if (valid_a && rdy_a) begin
            if (b2b_arm) begin
               check("a_b2b_accept_cycle", cyc, last_done_a);
               b2b_arm    = 1'b0;
               cs_gap_chk = 1'b1;
            end
            acc_a   = cyc;
            nbits_a = 0;
            cslo_a  = 0;
            rdyhi_a = 0;
            inx_a   = 1'b1;
         end else if (inx_a) begin
            if (!cs_n_a) cslo_a++;
            if (rdy_a) rdyhi_a++;
         end
         if (cs_n_a) begin
            hirun_a++;
         end else begin
            if (cs_prev_a && cs_gap_chk) begin
               check("a_cs_gap", hirun_a, 1);
               cs_gap_chk = 1'b0;
            end
            hirun_a = 0;
         end
      end
      sclk_prev_a = sclk_a;
      cs_prev_a   = cs_n_a;
   end

   // Monitor B: DIV=0 instance, SCLK must toggle on consecutive cycles.
   logic [W-1:0] bits_b = '0;
   int nbits_b = 0, acc_b = 0, cslo_b = 0, tog_b = 0, tog_first_b = 0, tog_last_b = 0;
   bit inx_b = 1'b0, sclk_prev_b = 1'b0;

   always @(negedge clk) begin
      logic [W-1:0] w, r;
      if (!rst_n) begin
         inx_b = 1'b0;
      end else begin
         if (sclk_b != sclk_prev_b) begin
            if (tog_b == 0) tog_first_b = cyc;
            tog_last_b = cyc;
            tog_b++;
         end
         if (sclk_b && !sclk_prev_b) begin
            bits_b = {bits_b[W-2:0], mosi_b};
            nbits_b++;
         end
         if (done_b) begin
            check("b_pending", 32'(exp_b_q.size() != 0), 32'd1);
            if (exp_b_q.size() != 0) begin
               w = exp_b_q.pop_front();
               r = exp_rd_b_q.pop_front();
               check("b_word", 32'(bits_b), 32'(w));
               check("b_rises", nbits_b, W);
               check("b_latency", cyc - acc_b, LAT_B);
               check("b_cs_low", cslo_b, CSLO_B);
               check("b_sclk_toggles", tog_b, 2 * W);
               check("b_sclk_span", tog_last_b - tog_first_b, 2 * W - 1);
               check("b_rdata", 32'(rdata_b), 32'(r));
            end
            inx_b = 1'b0;
         end
         if (valid_b && rdy_b) begin
            acc_b   = cyc;
            nbits_b = 0;
            cslo_b  = 0;
            tog_b   = 0;
            inx_b   = 1'b1;
         end else if (inx_b && !cs_n_b) begin
            cslo_b++;
         end
      end
      sclk_prev_b = sclk_b;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready_a();
      int g = 0;
      while (!rdy_a && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      check("a_ready_wait", 32'(rdy_a), 32'd1);
   endtask

   task automatic send_a(input logic [W-1:0] w);
      @(posedge clk); #1;
      wait_ready_a();
      data_a  = w;
      valid_a = 1'b1;
      exp_q.push_back(w);
      exp_rd_q.push_back(RB ? w : '0);
      @(posedge clk); #1;
      valid_a = 1'b0;
      data_a  = '0;
   endtask

   task automatic send_b(input logic [W-1:0] w);
      @(posedge clk); #1;
      data_b  = w;
      valid_b = 1'b1;
      exp_b_q.push_back(w);
      exp_rd_b_q.push_back(RB ? w : '0);
      @(posedge clk); #1;
      valid_b = 1'b0;
      data_b  = '0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_q.size() + exp_b_q.size()) != 0 && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      check("drain", exp_q.size() + exp_b_q.size(), 0);
      exp_q.delete();
      exp_rd_q.delete();
      exp_b_q.delete();
      exp_rd_b_q.delete();
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_ready"}, 32'(rdy_a), 32'd1);
      check({tag, "_done"},  32'(done_a), 32'd0);
      check({tag, "_sclk"},  32'(sclk_a), 32'd0);
      check({tag, "_mosi"},  32'(mosi_a), 32'd0);
      check({tag, "_cs_n"},  32'(cs_n_a), 32'd1);
      check({tag, "_rdata"}, 32'(rdata_a), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int g;
      repeat (3) @(posedge clk);
      #1;
      check_reset_pins("por");
      check("por_b_ready", 32'(rdy_b), 32'd1);
      rst_n = 1'b1;

      // MOSI at rises must read 1,0,1,0,0,1,0,1.
      send_a(8'hA5);
      wait_idle();
      send_a(8'h5A);
      wait_idle();

      // Asynchronous reset 20 cycles into a transfer.
      send_a(8'hC3);
      repeat (19) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_reset_pins("midrst");
      exp_q.delete();
      exp_rd_q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Back-to-back: i_valid held high across two words.
      @(posedge clk); #1;
      data_a  = 8'h01;
      valid_a = 1'b1;
      exp_q.push_back(8'h01);
      exp_rd_q.push_back(RB ? 8'h01 : 8'h00);
      @(posedge clk); #1;
      check("a_b2b_first_taken", 32'(rdy_a), 32'd0);
      data_a  = 8'h80;
      exp_q.push_back(8'h80);
      exp_rd_q.push_back(RB ? 8'h80 : 8'h00);
      b2b_arm = 1'b1;
      g = 0;
      while (!rdy_a && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      check("a_b2b_done_ready", 32'(rdy_a), 32'd1);
      @(posedge clk); #1;
      valid_a = 1'b0;
      data_a  = '0;
      check("a_b2b_second_taken", 32'(rdy_a), 32'd0);
      wait_idle();

      // A word offered mid-transfer must be dropped.
      send_a(8'h96);
      repeat (10) @(posedge clk);
      #1;
      data_a  = 8'hFF;
      valid_a = 1'b1;
      check("a_busy_ready", 32'(rdy_a), 32'd0);
      @(posedge clk); #1;
      valid_a = 1'b0;
      data_a  = '0;
      wait_idle();

      // DIV=0 instance.
      send_b(8'h3C);
      wait_idle();

      // Quiet period: any stray o_done would pop an empty queue.
      repeat (100) @(posedge clk);
      #1;
      check("final_ready_a", 32'(rdy_a), 32'd1);
      check("final_cs_n_a", 32'(cs_n_a), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
